// File: rtl/bsg_pg_sum_pipe.sv
// Sum/carry/overflow stage behind a prefix (PG) carry tree, registered in a 2-entry valid/ready skid buffer.
// Define BSG_PG_SUM_PIPE_ZERO_FLAG_EN to add a per-entry zero_o flag (sum == 0).
module bsg_pg_sum_pipe #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] hs_i,
  input  logic [width_p-1:0] gg_i,
  input  logic               c_i,
  output logic               v_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] sum_o,
  output logic               cout_o,
`ifdef BSG_PG_SUM_PIPE_ZERO_FLAG_EN
  output logic               zero_o,
`endif
  output logic               ovf_o
);

  if (width_p < 2) begin : g_bad_width
    $error("bsg_pg_sum_pipe: width_p must be >= 2");
  end

  typedef struct packed {
    logic [width_p-1:0] sum;
    logic               cout;
    logic               ovf;
`ifdef BSG_PG_SUM_PIPE_ZERO_FLAG_EN
    logic               zero;
`endif
  } entry_s;

  entry_s       mem_r [2];
  entry_s       new_e;
  logic [1:0]   count_r;
  logic         head_r, tail_r;
  logic         enq, deq;

  // Carry into bit k is the group generate of bit k-1; bit 0 takes the carry-in.
  always_comb begin
    new_e      = '0;
    new_e.sum  = hs_i ^ {gg_i[width_p-2:0], c_i};
    new_e.cout = gg_i[width_p-1];
    new_e.ovf  = gg_i[width_p-1] ^ gg_i[width_p-2];
`ifdef BSG_PG_SUM_PIPE_ZERO_FLAG_EN
    new_e.zero = (new_e.sum == '0);
`endif
  end

  assign ready_o = (count_r != 2'd2);
  assign v_o     = (count_r != 2'd0);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= 2'd0;
      head_r  <= 1'b0;
      tail_r  <= 1'b0;
      mem_r[0] <= '0;
      mem_r[1] <= '0;
    end else begin
      if (enq) begin
        mem_r[tail_r] <= new_e;
        tail_r        <= ~tail_r;
      end
      if (deq) head_r <= ~head_r;
      case ({enq, deq})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign sum_o  = mem_r[head_r].sum;
  assign cout_o = mem_r[head_r].cout;
  assign ovf_o  = mem_r[head_r].ovf;
`ifdef BSG_PG_SUM_PIPE_ZERO_FLAG_EN
  assign zero_o = mem_r[head_r].zero;
`endif

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    !(yumi_i && count_r == 2'd0));

endmodule

// File: tb/tb_bsg_pg_sum_pipe.sv
// Random + directed bench for bsg_pg_sum_pipe (width_p=8) against a queue model of a+b+c_i.
module tb_bsg_pg_sum_pipe;
  localparam int W = 8;

  logic         clk_i = 1'b0, reset_i, v_i, ready_o, c_i, v_o, yumi_i, cout_o, ovf_o;
  logic [W-1:0] hs_i, gg_i, sum_o;
`ifdef BSG_PG_SUM_PIPE_ZERO_FLAG_EN
  logic         zero_o;
`endif

  bsg_pg_sum_pipe #(.width_p(W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
    .hs_i(hs_i), .gg_i(gg_i), .c_i(c_i), .v_o(v_o), .yumi_i(yumi_i),
    .sum_o(sum_o), .cout_o(cout_o),
`ifdef BSG_PG_SUM_PIPE_ZERO_FLAG_EN
    .zero_o(zero_o),
`endif
    .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int a; int b; int c; } op_t;
  op_t q[$];
  op_t cur;
  int  nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  // Drive operands as the prefix tree would present them.
  task automatic set_ops(input int a, input int b, input int c);
    logic [W-1:0] g;
    for (int k = 0; k < W; k++) begin
      int m;
      m = (1 << (k+1)) - 1;
      g[k] = (((a & m) + (b & m) + c) >> (k+1)) & 1;
    end
    cur  = '{a, b, c};
    hs_i = W'(a ^ b);
    gg_i = g;
    c_i  = c[0];
  endtask

  task automatic step();
    bit acc, dq;
    op_t h;
    int s, ea7, eb7, es7;
    acc = v_i && !reset_i && (q.size() < 2);
    dq  = yumi_i && !reset_i && (q.size() > 0);
    @(posedge clk_i); #1;
    if (reset_i) q.delete();
    else begin
      if (dq) void'(q.pop_front());
      if (acc) q.push_back(cur);
    end
    chk("v_o", 32'(v_o), 32'(q.size() != 0));
    chk("ready_o", 32'(ready_o), 32'(q.size() < 2));
    if (q.size() != 0) begin
      h = q[0];
      s = h.a + h.b + h.c;
      ea7 = (h.a >> 7) & 1; eb7 = (h.b >> 7) & 1; es7 = (s >> 7) & 1;
      chk("sum_o", 32'(sum_o), s & 255);
      chk("cout_o", 32'(cout_o), (s >> 8) & 1);
      chk("ovf_o", 32'(ovf_o), 32'((ea7 == eb7) && (es7 != ea7)));
`ifdef BSG_PG_SUM_PIPE_ZERO_FLAG_EN
      chk("zero_o", 32'(zero_o), 32'((s & 255) == 0));
`endif
    end
  endtask

  initial begin
    int stall;
    reset_i = 1; v_i = 0; yumi_i = 0; set_ops(0, 0, 0);
    step(); step();
    reset_i = 0;
    step();
    chk("rst_v", 32'(v_o), 0);   chk("rst_rdy", 32'(ready_o), 1);
    chk("rst_sum", 32'(sum_o), 0); chk("rst_cout", 32'(cout_o), 0); chk("rst_ovf", 32'(ovf_o), 0);
`ifdef BSG_PG_SUM_PIPE_ZERO_FLAG_EN
    chk("rst_zero", 32'(zero_o), 0);
`endif

    // signed overflow into the sign bit
    set_ops(8'h7F, 1, 0); v_i = 1; step(); v_i = 0;
    chk("t1_v", 32'(v_o), 1); chk("t1_sum", 32'(sum_o), 32'h80);
    chk("t1_cout", 32'(cout_o), 0); chk("t1_ovf", 32'(ovf_o), 1); chk("t1_rdy", 32'(ready_o), 1);
    yumi_i = 1; step(); yumi_i = 0;

    // wrap to zero with carry-out
    set_ops(8'hFF, 1, 0); v_i = 1; step(); v_i = 0;
    chk("t2_sum", 32'(sum_o), 0); chk("t2_cout", 32'(cout_o), 1); chk("t2_ovf", 32'(ovf_o), 0);
`ifdef BSG_PG_SUM_PIPE_ZERO_FLAG_EN
    chk("t2_zero", 32'(zero_o), 1);
`endif
    yumi_i = 1; step(); yumi_i = 0;

    // fill to full; third offer must be refused
    for (int k = 1; k <= 3; k++) begin
      set_ops(k, 0, 0); v_i = 1; step();
      if (k >= 2) chk("full_rdy", 32'(ready_o), 0);
    end
    v_i = 0;
    chk("full_head", 32'(sum_o), 1);
    yumi_i = 1; step(); chk("full_pop1", 32'(sum_o), 2);
    step(); yumi_i = 0;
    chk("full_empty", 32'(v_o), 0);

    // simultaneous enqueue/dequeue at count=1
    set_ops(5, 6, 0); v_i = 1; step();
    set_ops(9, 9, 1); yumi_i = 1; step();
    chk("sim_v", 32'(v_o), 1); chk("sim_sum", 32'(sum_o), 19); chk("sim_rdy", 32'(ready_o), 1);
    v_i = 0; step(); yumi_i = 0;

    // reset mid-operation discards entries and ignores v_i
    set_ops(3, 4, 0); v_i = 1; step();
    set_ops(10, 20, 0); step();
    set_ops(1, 1, 0); reset_i = 1; step();
    reset_i = 0; v_i = 0;
    chk("mrst_v", 32'(v_o), 0); chk("mrst_sum", 32'(sum_o), 0); chk("mrst_rdy", 32'(ready_o), 1);
    step();
    chk("mrst_v2", 32'(v_o), 0);

    // full-throughput streaming
    stall = 0; v_i = 1;
    for (int i = 0; i < 1000; i++) begin
      set_ops($urandom_range(255), $urandom_range(255), $urandom_range(1));
      yumi_i = (q.size() > 0);
      step();
      if (!ready_o) stall++;
    end
    chk("stream_stall", 32'(stall), 0);
    v_i = 0;
    while (q.size() > 0) begin yumi_i = 1; step(); end
    yumi_i = 0;

    // random handshake
    for (int i = 0; i < 400; i++) begin
      set_ops($urandom_range(255), $urandom_range(255), $urandom_range(1));
      v_i    = $urandom_range(1);
      yumi_i = (q.size() > 0) && ($urandom_range(1) == 1);
      step();
    end
    v_i = 0; yumi_i = 0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/bsg_pg_sum_pipe.md
Name: bsg_pg_sum_pipe

Overview:
Downstream consumer of a prefix (PG) carry network. It takes per-bit half-sums and group-generate (carry) bits from the prefix tree plus the carry-in, forms sum, carry-out and signed overflow, and registers them in a 2-entry valid/ready skid buffer. This sits between the combinational prefix tree and the next pipeline stage of an adder or ALU datapath, so the tree's output can be timing-isolated and backpressured.

Parameters:
width_p, "inv", number of sum bits; must be >= 2 (elaboration error otherwise)

Ports:
clk_i  input  1  clock; all state updates on rising edge
reset_i  input  1  synchronous, active-high reset
v_i  input  1  input valid
ready_o  output  1  block can accept an input this cycle
hs_i  input  width_p  half-sum bits, hs_i[k] = a[k]^b[k]
gg_i  input  width_p  group generate from prefix tree; gg_i[k] = carry out of bit k (includes carry-in)
c_i  input  1  carry-in
v_o  output  1  output valid
yumi_i  input  1  downstream consumes head entry; legal only when v_o=1
sum_o  output  width_p  registered sum
cout_o  output  1  registered carry-out
ovf_o  output  1  registered signed overflow

Behaviour:
- Interface: one clock (clk_i); reset_i synchronous, active-high.
- Arithmetic, computed combinationally before storage: sum[0] = hs_i[0]^c_i; sum[k] = hs_i[k]^gg_i[k-1] for k>=1; cout = gg_i[width_p-1]; ovf = gg_i[width_p-1]^gg_i[width_p-2].
- Storage: 2 entries, FIFO order, 2-bit count (0..2), 1-bit head pointer, 1-bit tail pointer.
- Enqueue when v_i & ready_o & ~reset_i. Dequeue when yumi_i.
- ready_o = (count != 2), derived from state only, with no combinational path from v_i or yumi_i.
- v_o = (count != 0). sum_o, cout_o and ovf_o always show the head slot.
- Latency: data enqueued at edge N is visible with v_o=1 after edge N. No same-cycle bypass.
- Count transitions:
  - enqueue only: +1
  - dequeue only: -1
  - both: unchanged, pointers both advance
  - count=2: ready_o=0, so no enqueue, and yumi_i frees one slot at the edge
  - count=0: yumi_i is illegal; assertion fires in sim, state unchanged
- Reset: count=0, pointers=0, storage=0, so v_o=0, sum_o=0, cout_o=0, ovf_o=0, ready_o=1 from the cycle after reset. Inputs are ignored while reset_i=1.
- Reset mid-operation: all held entries are discarded at that edge.
- When v_o=0, outputs show the stale head slot. The bench must not check them.

Optional Feature:
BSG_PG_SUM_PIPE_ZERO_FLAG_EN
- Defined: extra output port zero_o (1 bit), stored per entry, = (sum == 0). It follows the same head-slot and reset rules as sum_o (reset value 0).
- Undefined: no zero_o port and no extra storage.
- Either way, sum_o, cout_o, ovf_o and the handshake are identical.

Test Plan:
- width_p=8. Operands a=0x7F, b=0x01, c_i=0 give hs_i=0x7E, gg_i=0x7F; v_i=1 for one cycle, yumi_i=0 -> next cycle v_o=1, sum_o=0x80, cout_o=0, ovf_o=1, ready_o=1 (zero_o=0 if enabled).
- Operands a=0xFF, b=0x01, c_i=0 give hs_i=0xFE, gg_i=0xFF -> sum_o=0x00, cout_o=1, ovf_o=0 (zero_o=1 if enabled).
- Fill to full: three consecutive v_i with sums 0x01, 0x02, 0x03 and yumi_i=0 -> ready_o=0 after the 2nd accept; the 3rd is not accepted; then yumi_i on two cycles returns 0x01 then 0x02, and v_o=0 afterwards.
- Simultaneous at count=1: v_i=1 and yumi_i=1 in the same cycle -> count stays 1, v_o stays 1, head advances to the new entry, ready_o stays 1.
- Reset mid-operation: two entries held, reset_i=1 for one cycle -> v_o=0, sum_o=0, ready_o=1 the cycle after reset deasserts; a v_i asserted during reset is not stored.
- Streaming: v_i=1 and yumi_i=1 every cycle with random operands for 1000 cycles -> full throughput (ready_o never 0), outputs equal the golden a+b+c_i delayed by 1 cycle.
